// File: rtl/rca_accumulator.sv
// Streaming burst accumulator: sums N-bit words into an N+G-bit register.
// Optional RCA_ACC_SAT_EN saturates the sum at all-ones after overflow.
module rca_accumulator #(
  parameter int N = 8,
  parameter int G = 2,
  parameter int C = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+G-1:0]   out_sum,
  output logic [C-1:0]     out_count,
  output logic             out_ovf
);

  localparam int W = N + G;

  typedef enum logic {ACC, HOLD} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   acc;
  logic [C-1:0]   cnt;
  logic           ovf;
  logic [W:0]     add;
  logic [W-1:0]   acc_nxt;
  logic [C-1:0]   cnt_nxt;
  logic           ovf_nxt;
  logic           accept;
  logic           burst_end;
  logic           drain;

  assign in_ready  = (state == ACC);
  assign accept    = in_valid && in_ready;
  assign add       = {1'b0, acc} + {{(G+1){1'b0}}, in_data};
  assign ovf_nxt   = ovf | add[W];
  assign cnt_nxt   = cnt + 1'b1;
  // A full counter forces the burst closed regardless of in_last.
  assign burst_end = accept && (in_last || (cnt_nxt == {C{1'b1}}));
  assign drain     = out_valid && out_ready;

`ifdef RCA_ACC_SAT_EN
  assign acc_nxt = ovf_nxt ? {W{1'b1}} : add[W-1:0];
`else
  assign acc_nxt = add[W-1:0];
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACC:  if (burst_end) state_nxt = HOLD;
      HOLD: if (drain)     state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
        ovf <= ovf_nxt;
      end
      if (burst_end) begin
        out_valid <= 1'b1;
        out_sum   <= acc_nxt;
        out_count <= cnt_nxt;
        out_ovf   <= ovf_nxt;
      end
      if (drain) begin
        out_valid <= 1'b0;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rca_accumulator.sv
// Randomised scoreboard bench for rca_accumulator.
// Reference model keeps plain integer burst totals.
module tb_rca_accumulator;

  localparam int N = 8;
  localparam int G = 2;
  localparam int C = 4;
  localparam int W = N + G;
  localparam int MAXW = (1 << C) - 1;
  localparam int MAXS = (1 << W) - 1;

  typedef struct {
    int unsigned sum;
    int unsigned count;
    int unsigned ovf;
  } res_t;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         in_last = 0;
  logic         out_valid;
  logic         out_ready = 1;
  logic [W-1:0] out_sum;
  logic [C-1:0] out_count;
  logic         out_ovf;

  int n_checks = 0;
  int n_fail = 0;
  bit rand_ready = 0;

  res_t        sb[$];
  int unsigned m_total = 0;
  int unsigned m_cnt = 0;

  rca_accumulator #(.N(N), .G(G), .C(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count),
    .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act,
                     input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_accept(input int unsigned d,
                                       input bit l);
    res_t r;
    m_total += d;
    m_cnt++;
    if (l || m_cnt == MAXW) begin
      r.ovf = (m_total > MAXS) ? 1 : 0;
`ifdef RCA_ACC_SAT_EN
      r.sum = r.ovf ? MAXS : m_total;
`else
      r.sum = m_total % (MAXS + 1);
`endif
      r.count = m_cnt;
      sb.push_back(r);
      m_total = 0;
      m_cnt = 0;
    end
  endfunction

  // Caller sits at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input int unsigned d, input bit l);
    int  n;
    bit  r;
    in_valid = 1;
    in_data  = d[N-1:0];
    in_last  = l;
    n = 0;
    r = 0;
    while (1) begin
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    if (r) model_accept(d, l);
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    res_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_sum", out_sum, e.sum);
        chk("out_count", out_count, e.count);
        chk("out_ovf", out_ovf, e.ovf);
      end
    end
  end

  initial begin
    logic [W-1:0] held;
    int unsigned  nw;

    rst_n = 0;
    idle(3);
    rst_n = 1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Basic burst with out_valid lasting one cycle.
    out_ready = 1;
    send(8'h10, 0);
    send(8'h20, 0);
    send(8'h30, 1);
    chk("basic_out_valid", out_valid, 1);
    chk("basic_in_ready_hold", in_ready, 0);
    idle(1);
    chk("basic_valid_drop", out_valid, 0);
    chk("basic_in_ready_back", in_ready, 1);

    // Backpressure: outputs held, input stalls.
    out_ready = 0;
    send(8'h10, 0);
    send(8'h20, 0);
    send(8'h30, 1);
    held = out_sum;
    chk("bp_held_sum", held, 10'h060);
    in_valid = 1;
    in_data  = 8'h77;
    in_last  = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum_stable", out_sum, held);
      chk("bp_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    out_ready = 1;
    send(8'h01, 1);
    drain_wait();

    // Overflow over five 0xFF words.
    for (int i = 0; i < 5; i++) send(8'hFF, i == 4);
    @(negedge clk);
`ifdef RCA_ACC_SAT_EN
    chk("ovf_sum_const", out_sum, 10'h3FF);
`else
    chk("ovf_sum_const", out_sum, 10'h0FB);
`endif
    chk("ovf_flag_const", out_ovf, 1);
    @(posedge clk);
    #1;
    drain_wait();

    // Forced end at 15 words.
    for (int i = 0; i < 15; i++) send(8'h01, 0);
    @(negedge clk);
    chk("forced_valid", out_valid, 1);
    chk("forced_count_const", out_count, 15);
    @(posedge clk);
    #1;
    drain_wait();

    // Reset mid-burst discards the partial sum.
    send(8'h40, 0);
    send(8'h40, 0);
    rst_n = 0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_sum", out_sum, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    m_total = 0;
    m_cnt = 0;
    idle(2);
    rst_n = 1;
    idle(1);
    send(8'h05, 1);
    drain_wait();

    // Random bursts with random gaps and backpressure.
    rand_ready = 1;
    for (int b = 0; b < 40; b++) begin
      nw = $urandom_range(1, 18);
      for (int i = 0; i < int'(nw); i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send($urandom_range(0, 255), i == int'(nw) - 1);
      end
    end
    rand_ready = 0;
    out_ready = 1;
    drain_wait();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
